kbd_fifo: RTL and testbench
===========================

Name: kbd_fifo

Overview:
Keyboard input stage that sits directly upstream of the cpu `keyboard`/`en_inp` inputs in the SoC top.
- Synchronises the asynchronous pad strobe and pad data into the `clk` domain.
- Detects each strobe rising edge and pushes the byte into a small FIFO.
- Presents the head byte to the cpu with a valid flag; the cpu pops it with a one-cycle read pulse.
- Keystrokes arriving while the cpu is busy are no longer lost; FIFO overflow is flagged.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
DATA_W, 8, keystroke width in bits.
SYNC_STAGES, 2, synchroniser flops on pad_strobe and pad_data; >= 2.
DEBOUNCE_CYCLES, 4, consecutive high cycles required on the synced strobe; used only with KBD_FIFO_DEBOUNCE_EN.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous assert, active-low.
pad_data  in  DATA_W  keyboard byte from pads; async; stable around the strobe.
pad_strobe  in  1  key-ready strobe from pads; async, active-high.
rd  in  1  cpu pop pulse; one entry consumed per cycle high while valid.
clr_ovf  in  1  synchronous clear of overflow.
dout  out  DATA_W  head entry; 0 when empty.
valid  out  1  FIFO non-empty.
full  out  1  count == DEPTH.
overflow  out  1  sticky; a push was dropped because the FIFO was full.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state is cleared on reset assertion with no clock required.
- Reset values: dout=0, valid=0, full=0, overflow=0, count=0, read/write pointers=0, all synchroniser and edge flops=0.
- Synchronisers:
  - pad_strobe passes through a SYNC_STAGES flop chain, giving s_sync.
  - pad_data passes through an identical-depth chain, giving d_sync, so data and strobe stay aligned.
  - One further flop holds s_prev.
- Push condition: push = s_sync & ~s_prev. Exactly one push per strobe high period, regardless of how long the strobe stays high.
- Latency (SYNC_STAGES=2): strobe first sampled high at edge k.
  - Entry is written at edge k+2.
  - valid and dout update after edge k+2.
  - pad_data must be stable from edge k-1 through edge k+1.
- pop = rd & valid. rd while empty is ignored and has no side effects.
- Storage: DEPTH x DATA_W register array.
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately.
- dout = mem[rd_ptr] when valid, else 0. Combinational from registers; no read latency. The next entry appears the cycle after a pop.
- count update rules:
  - push only, not full: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged. Both pointers advance, including when full (the slot freed by the pop is used).
  - push while full with no pop: entry dropped, pointers and count unchanged, overflow set to 1.
  - push while empty with rd high: push accepted, rd ignored, count becomes 1.
- overflow:
  - Sticky until clr_ovf=1 or reset.
  - If clr_ovf and a dropped push coincide in the same cycle, the set wins and overflow stays 1.
- full = (count==DEPTH); valid = (count!=0). Both are derived from the registered count, never from comb inputs.
- Reset mid-operation: FIFO contents are discarded and the synchronisers are cleared. A strobe still high when rst_n releases produces a push, because s_prev was reset to 0.
- No combinational path from any input to any output except rd having no output effect; all outputs are functions of registers.

Optional Feature:
KBD_FIFO_DEBOUNCE_EN
- Defined:
  - A counter of $clog2(DEBOUNCE_CYCLES)+1 bits counts consecutive cycles with s_sync=1 and clears on s_sync=0.
  - The qualified strobe q goes high when the count reaches DEBOUNCE_CYCLES and stays high while s_sync=1.
  - push = q & ~q_prev.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no push.
  - Latency grows by DEBOUNCE_CYCLES-1 cycles; pad_data must stay stable for that extra time.
  - d_sync is captured at the push.
- Undefined: push = s_sync & ~s_prev as above. No counter is synthesised and DEBOUNCE_CYCLES is ignored.

Test Plan:
1. Reset, then pad_data=8'h41, pad_strobe high for 5 cycles -> valid=1 and dout=8'h41 exactly 3 edges after first sample; count=1; only one push.
2. Push 8'h01, 8'h02, 8'h03, 8'h04, then 8'h05 with no rd -> full=1, count=4, overflow=1; pops return 01, 02, 03, 04 in order; 05 is lost; then valid=0, dout=0.
3. FIFO full, rd pulse coincident with push of 8'h55 -> count stays 4, overflow stays 0; after three pops the fourth pop returns 8'h55.
4. rd held high while empty -> count stays 0, no pointer movement. clr_ovf high in the same cycle as a dropped push -> overflow=1.
5. rst_n low mid-stream with count=3 and a strobe in flight -> all outputs 0 immediately (asynchronous); strobe held high across reset release -> exactly one push.
6. With KBD_FIFO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: 2-cycle strobe glitch -> no push; 6-cycle strobe with 8'h7A -> single push, valid 3 cycles later than in scenario 1.

Source files
------------

// File: rtl/kbd_fifo.sv
// Keyboard input stage: pad strobe/data synchronisers, strobe edge detect, and a small pop-on-read FIFO.
// Optional strobe debounce is enabled by defining KBD_FIFO_DEBOUNCE_EN.
module kbd_fifo #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pad_data,
  input  logic                     pad_strobe,
  input  logic                     rd,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [SYNC_STAGES-1:0]             s_chain_q;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] d_chain_q;
  logic                               s_sync;
  logic [DATA_W-1:0]                  d_sync;
  logic                               push;

  assign s_sync = s_chain_q[SYNC_STAGES-1];
  assign d_sync = d_chain_q[SYNC_STAGES-1];

  // Data rides an identical-depth chain so it stays aligned with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_chain_q <= '0;
      d_chain_q <= '0;
    end else begin
      s_chain_q <= {s_chain_q[SYNC_STAGES-2:0], pad_strobe};
      d_chain_q <= {d_chain_q[SYNC_STAGES-2:0], pad_data};
    end
  end

`ifdef KBD_FIFO_DEBOUNCE_EN
  localparam int unsigned      DBW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DBW-1:0]   DB_MAX = DBW'(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0]   DB_ARM = DBW'(DEBOUNCE_CYCLES - 1);

  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           q_now, q_prev_q;

  always_comb begin
    db_cnt_d = '0;
    if (s_sync) db_cnt_d = (db_cnt_q == DB_MAX) ? DB_MAX : db_cnt_q + 1'b1;
  end

  // Qualifies in the cycle that completes DEBOUNCE_CYCLES consecutive highs.
  assign q_now = s_sync & (db_cnt_q >= DB_ARM);
  assign push  = q_now & ~q_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      q_prev_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      q_prev_q <= q_now;
    end
  end
`else
  logic        s_prev_q;
  logic [31:0] unused_dbnc;

  assign unused_dbnc = 32'(DEBOUNCE_CYCLES);
  assign push        = s_sync & ~s_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_prev_q <= 1'b0;
    else        s_prev_q <= s_sync;
  end
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full_c, pop, wr_en, drop;

  always_comb begin
    full_c   = (count_q == CW'(DEPTH));
    pop      = rd & (count_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    wr_en    = push & (~full_c | pop);
    drop     = push & full_c & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= d_sync;
  end

  assign valid    = (count_q != '0);
  assign full     = full_c;
  assign overflow = ovf_q;
  assign count    = count_q;
  assign dout     = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_kbd_fifo.sv
// Directed bench for kbd_fifo: queue-based model checked every cycle plus literal scenario checks.
module tb_kbd_fifo;
  localparam int DEPTH = 4;
`ifdef KBD_FIFO_DEBOUNCE_EN
  localparam int NEFF = 4;
`else
  localparam int NEFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pad_data = 8'h00;
  logic       pad_strobe = 1'b0;
  logic       rd = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] dout;
  logic       valid, full, overflow;
  logic [2:0] count;

  kbd_fifo #(.DEPTH(4), .DATA_W(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data), .pad_strobe(pad_strobe),
    .rd(rd), .clr_ovf(clr_ovf), .dout(dout), .valid(valid), .full(full),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a key is pushed two edges after the edge where the sampled strobe
  // has been high for NEFF consecutive edges; the byte is the one sampled then.
  byte unsigned mq[$];
  bit           m_ovf = 1'b0;
  int           h_run[2] = '{0, 0};
  logic [7:0]   h_dat[2] = '{8'h00, 8'h00};
  bit           m_pop, m_push, m_drop;
  int           m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      h_run = '{0, 0};
      h_dat = '{8'h00, 8'h00};
    end else begin
      m_pop  = rd && (mq.size() > 0);
      m_push = (h_run[1] == NEFF);
      m_drop = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(h_dat[1]);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_r = pad_strobe ? ((h_run[0] >= 255) ? 255 : h_run[0] + 1) : 0;
      h_run[1] = h_run[0];
      h_dat[1] = h_dat[0];
      h_run[0] = m_r;
      h_dat[0] = pad_data;
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'b0, valid}, {31'b0, mq.size() != 0});
    chk("count", {29'b0, count}, mq.size());
    chk("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("dout", {24'b0, dout}, (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] d, input int hi);
    pad_data = d;
    pad_strobe = 1'b1;
    cyc(hi);
    pad_strobe = 1'b0;
    cyc(3);
  endtask

  task automatic pop1();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_dout", {24'b0, dout}, 0);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    rst_n = 1'b1;
    cyc(2);

    // Scenario 1: latency and single push for a long strobe
    pad_data = 8'h41;
    pad_strobe = 1'b1;
    cyc(NEFF + 1);
    chk("s1_lat_early", {31'b0, valid}, 0);
    cyc(1);
    chk("s1_lat_valid", {31'b0, valid}, 1);
    chk("s1_lat_dout", {24'b0, dout}, 32'h41);
    cyc(4);
    pad_strobe = 1'b0;
    cyc(3);
    chk("s1_one_push", {29'b0, count}, 1);
    pop1();
    chk("s1_empty", {31'b0, valid}, 0);

    // Scenario 2: fill, overflow, ordered drain
    for (int i = 1; i <= 5; i++) strobe(8'(i), 6);
    chk("s2_full", {31'b0, full}, 1);
    chk("s2_count", {29'b0, count}, 4);
    chk("s2_ovf", {31'b0, overflow}, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("s2_pop_order", {24'b0, dout}, i);
      pop1();
    end
    chk("s2_drained_valid", {31'b0, valid}, 0);
    chk("s2_drained_dout", {24'b0, dout}, 0);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    chk("s2_ovf_clr", {31'b0, overflow}, 0);

    // Scenario 3: push and pop together while full
    strobe(8'h11, 6); strobe(8'h22, 6); strobe(8'h33, 6); strobe(8'h44, 6);
    chk("s3_full", {31'b0, full}, 1);
    pad_data = 8'h55;
    pad_strobe = 1'b1;
    cyc(NEFF + 1);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    chk("s3_count", {29'b0, count}, 4);
    chk("s3_ovf", {31'b0, overflow}, 0);
    cyc(5);
    pad_strobe = 1'b0;
    cyc(3);
    chk("s3_head", {24'b0, dout}, 32'h22);
    pop1(); pop1(); pop1();
    chk("s3_fourth", {24'b0, dout}, 32'h55);
    pop1();
    chk("s3_empty", {31'b0, valid}, 0);

    // Scenario 4: rd while empty, push with rd high, clr_ovf vs dropped push
    rd = 1'b1;
    cyc(3);
    chk("s4_rd_empty", {29'b0, count}, 0);
    pad_data = 8'h9A;
    pad_strobe = 1'b1;
    cyc(NEFF + 2);
    chk("s4_push_rd", {29'b0, count}, 1);
    chk("s4_push_rd_dout", {24'b0, dout}, 32'h9A);
    rd = 1'b0;
    cyc(4);
    pad_strobe = 1'b0;
    cyc(3);
    strobe(8'hB1, 6); strobe(8'hB2, 6); strobe(8'hB3, 6);
    chk("s4_full", {31'b0, full}, 1);
    pad_data = 8'hC4;
    pad_strobe = 1'b1;
    cyc(NEFF + 1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    chk("s4_set_wins", {31'b0, overflow}, 1);
    chk("s4_count", {29'b0, count}, 4);
    cyc(5);
    pad_strobe = 1'b0;
    cyc(3);

    // Scenario 5: asynchronous reset mid-stream, strobe held across release
    pop1();
    chk("s5_count3", {29'b0, count}, 3);
    pad_data = 8'h66;
    pad_strobe = 1'b1;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_valid", {31'b0, valid}, 0);
    chk("s5_async_count", {29'b0, count}, 0);
    chk("s5_async_dout", {24'b0, dout}, 0);
    chk("s5_async_full", {31'b0, full}, 0);
    chk("s5_async_ovf", {31'b0, overflow}, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(NEFF + 2);
    chk("s5_release_push", {29'b0, count}, 1);
    chk("s5_release_dout", {24'b0, dout}, 32'h66);
    cyc(3);
    pad_strobe = 1'b0;
    cyc(3);
    chk("s5_one_push", {29'b0, count}, 1);
    pop1();

`ifdef KBD_FIFO_DEBOUNCE_EN
    // Scenario 6: glitch rejection and debounced latency
    pad_data = 8'hE1;
    pad_strobe = 1'b1;
    cyc(2);
    pad_strobe = 1'b0;
    cyc(8);
    chk("s6_glitch", {29'b0, count}, 0);
    pad_data = 8'h7A;
    pad_strobe = 1'b1;
    cyc(5);
    chk("s6_lat_early", {31'b0, valid}, 0);
    cyc(1);
    chk("s6_lat_valid", {31'b0, valid}, 1);
    chk("s6_lat_dout", {24'b0, dout}, 32'h7A);
    pad_strobe = 1'b0;
    cyc(3);
    chk("s6_one_push", {29'b0, count}, 1);
    pop1();
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
